// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: 32-bit loads/stores over a 16-bit async SRAM as two half-word
// accesses, freezing the upstream pipeline via ready while an access runs.
module mem_stage_sram_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic        MEM_r_en_in,
  input  logic        MEM_w_en_in,
  input  logic [3:0]  dest_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm_in,
  output logic        WB_en_out,
  output logic        MEM_r_en_out,
  output logic [3:0]  dest_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N
);

  // state | meaning
  // IDLE  | waiting for a load/store request
  // LO    | low half-word on the SRAM bus for WAIT_CYCLES cycles
  // HI    | high half-word on the SRAM bus for WAIT_CYCLES cycles
  // DONE  | access complete, pipeline advances this cycle
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            we_n_q;
  logic            req;
  logic [16:0]     word_idx;

  assign WB_en_out    = WB_en_in;
  assign MEM_r_en_out = MEM_r_en_in;
  assign dest_out     = dest_in;
  assign alu_res_out  = alu_res_in;

  assign req      = MEM_r_en_in | MEM_w_en_in;
  assign word_idx = 17'((alu_res_in - 32'(ADDR_BASE)) >> 2);

  assign SRAM_ADDR = {word_idx, state == HI};
  assign SRAM_WE_N = we_n_q;
  // we_n_q is only low in LO/HI of a store, so it doubles as the bus drive enable
  assign SRAM_DQ   = !we_n_q ? ((state == HI) ? val_rm_in[31:16] : val_rm_in[15:0]) : 16'hzzzz;

  assign ready = !((state == IDLE && req) || state == LO || state == HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_data <= '0;
      we_n_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt    <= CNT_LOAD;
            we_n_q <= ~MEM_w_en_in;
            state  <= LO;
          end
        end
        LO: begin
          if (cnt == '0) begin
            if (we_n_q) mem_data[15:0] <= SRAM_DQ;
            cnt   <= CNT_LOAD;
            state <= HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HI: begin
          if (cnt == '0) begin
            if (we_n_q) mem_data[31:16] <= SRAM_DQ;
            we_n_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural SRAM that
// drives the bus whenever WE_N is high and writes on clock edges with WE_N low.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_en_in, MEM_r_en_in, MEM_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic        WB_en_out, MEM_r_en_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_res_out, mem_data;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N;

  logic [15:0] sram [64];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .WB_en_in(WB_en_in), .MEM_r_en_in(MEM_r_en_in), .MEM_w_en_in(MEM_w_en_in),
    .dest_in(dest_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
    .WB_en_out(WB_en_out), .MEM_r_en_out(MEM_r_en_out), .dest_out(dest_out),
    .alu_res_out(alu_res_out), .mem_data(mem_data), .ready(ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N)
  );

  // SRAM model: output enabled whenever not writing
  assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR[5:0]] : 16'hzzzz;

  always @(posedge clk)
    if (!SRAM_WE_N) sram[SRAM_ADDR[5:0]] <= SRAM_DQ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one memory instruction starting just after a rising edge and checks
  // the 6 cycles it occupies (5 frozen + DONE), then returns just after the DONE edge.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [17:0] exp_lo, input logic [31:0] exp_md);
    logic exp_we_n;
    logic [17:0] exp_addr;
    MEM_r_en_in = rd; MEM_w_en_in = wr; alu_res_in = addr; val_rm_in = data;
    WB_en_in = rd; dest_in = 4'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_we_n = !(wr && i >= 1 && i <= 4);
      exp_addr = (i == 3 || i == 4) ? exp_lo + 18'd1 : exp_lo;
      chk($sformatf("%s_ready_c%0d", tag, i), {31'd0, ready}, {31'd0, (i == 5)});
      chk($sformatf("%s_we_n_c%0d", tag, i), {31'd0, SRAM_WE_N}, {31'd0, exp_we_n});
      chk($sformatf("%s_addr_c%0d", tag, i), {14'd0, SRAM_ADDR}, {14'd0, exp_addr});
      if (wr && (i == 1 || i == 2))
        chk($sformatf("%s_dq_lo_c%0d", tag, i), {16'd0, SRAM_DQ}, {16'd0, data[15:0]});
      if (wr && (i == 3 || i == 4))
        chk($sformatf("%s_dq_hi_c%0d", tag, i), {16'd0, SRAM_DQ}, {16'd0, data[31:16]});
    end
    chk({tag, "_mem_data_done"}, mem_data, exp_md);
    @(posedge clk); #1;
    MEM_r_en_in = 1'b0; MEM_w_en_in = 1'b0; WB_en_in = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) sram[i] = 16'h5A00 | 16'(i);
    rst = 1'b1;
    WB_en_in = 0; MEM_r_en_in = 0; MEM_w_en_in = 0;
    dest_in = 0; alu_res_in = 32'd1024; val_rm_in = 0;
    #3;
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_dq_hiz", {16'd0, SRAM_DQ}, 32'h5A00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // store 0xDEADBEEF at 1032 -> SRAM words 4/5
    run_access("st1032", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'd0);
    chk("st1032_sram_lo", {16'd0, sram[4]}, 32'h0000BEEF);
    chk("st1032_sram_hi", {16'd0, sram[5]}, 32'h0000DEAD);
    @(negedge clk);
    chk("st1032_idle_dq_hiz", {16'd0, SRAM_DQ}, 32'h0000BEEF);
    chk("st1032_idle_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    @(posedge clk); #1;

    run_access("ld1032", 1'b1, 1'b0, 32'd1032, 32'h0, 18'd4, 32'hDEADBEEF);

    // non-memory instruction: pass-through, ready stays high
    WB_en_in = 1; dest_in = 4'd7; alu_res_in = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("nonmem_ready_c%0d", i), {31'd0, ready}, 32'd1);
      chk($sformatf("nonmem_we_n_c%0d", i), {31'd0, SRAM_WE_N}, 32'd1);
    end
    chk("nonmem_wb", {31'd0, WB_en_out}, 32'd1);
    chk("nonmem_rd", {31'd0, MEM_r_en_out}, 32'd0);
    chk("nonmem_dest", {28'd0, dest_out}, 32'd7);
    chk("nonmem_alu", alu_res_out, 32'h12345678);
    chk("nonmem_mem_data", mem_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    WB_en_in = 0;

    // both enables -> store to 1036 (words 6/7)
    run_access("both1036", 1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 18'd6, 32'hDEADBEEF);
    chk("both1036_sram_lo", {16'd0, sram[6]}, 32'h0000F00D);
    chk("both1036_sram_hi", {16'd0, sram[7]}, 32'h0000CAFE);

    // back-to-back store then load at 1024 (words 0/1)
    run_access("b2b_st", 1'b0, 1'b1, 32'd1024, 32'h13572468, 18'd0, 32'hDEADBEEF);
    run_access("b2b_ld", 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'h13572468);

    // wrap: 1020 -> word index 2^17-1
    run_access("wrap1020", 1'b1, 1'b0, 32'd1020, 32'h0, 18'h3FFFE, 32'h5A3F5A3E);

    // reset during HI of a load from 1036
    MEM_r_en_in = 1; alu_res_in = 32'd1036;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("rstmid_in_hi_addr", {14'd0, SRAM_ADDR}, 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_mem_data", mem_data, 32'd0);
    chk("rstmid_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rstmid_idle_addr", {14'd0, SRAM_ADDR}, 32'd6);
    chk("rstmid_ready_req", {31'd0, ready}, 32'd0);
    chk("rstmid_dq_hiz", {16'd0, SRAM_DQ}, 32'h0000F00D);
    @(posedge clk); #1;
    rst = 1'b0;
    run_access("rstmid_restart", 1'b1, 1'b0, 32'd1036, 32'h0, 18'd6, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
